// File: rtl/rx_fifo_drain_ctrl_pkg.sv
// rtl/rx_fifo_drain_ctrl_pkg.sv - shared types, widths and burst-length helper for the RX drain controller
package qspi_rx_pkg;

  localparam int FIFO_DEPTH = 16;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int TMO_W      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } drain_state_t;

  // Burst length actually used: 0 means a single word, anything past the FIFO depth is clipped.
  function automatic logic [LVL_W-1:0] eff_len(input logic [LVL_W-1:0] len);
    if (len == '0) begin
      eff_len = LVL_W'(1);
    end else if (len > LVL_W'(FIFO_DEPTH)) begin
      eff_len = LVL_W'(FIFO_DEPTH);
    end else begin
      eff_len = len;
    end
  endfunction

endpackage

// File: rtl/rx_fifo_drain_ctrl_if.sv
// rtl/rx_fifo_drain_ctrl_if.sv - FIFO read-side, CSR and DMA signals of the RX drain controller
interface rx_fifo_drain_ctrl_if;
  import qspi_rx_pkg::*;

  logic             cfg_dma_en;
  logic [LVL_W-1:0] cfg_burst_len;
  logic [TMO_W-1:0] cfg_timeout;
  logic [LVL_W-1:0] fifo_level;
  logic             fifo_empty;
  logic             csr_rd_req;
  logic             fifo_csr_re;
  logic             fifo_dma_re;
  logic             dma_req;
  logic [LVL_W-1:0] dma_len;
  logic             dma_valid;
  logic             dma_ready;
  logic             burst_done;
  logic             flush_evt;
  logic             csr_conflict;
  logic             csr_underrun;

  // Controller view: owns the FIFO read strobes and the DMA request side.
  modport master (
    input  cfg_dma_en, cfg_burst_len, cfg_timeout,
    input  fifo_level, fifo_empty, csr_rd_req, dma_ready,
    output fifo_csr_re, fifo_dma_re, dma_req, dma_len, dma_valid,
    output burst_done, flush_evt, csr_conflict, csr_underrun
  );

  // Surrounding FIFO/CSR/DMA view.
  modport slave (
    output cfg_dma_en, cfg_burst_len, cfg_timeout,
    output fifo_level, fifo_empty, csr_rd_req, dma_ready,
    input  fifo_csr_re, fifo_dma_re, dma_req, dma_len, dma_valid,
    input  burst_done, flush_evt, csr_conflict, csr_underrun
  );

endinterface

// File: rtl/rx_fifo_drain_ctrl_timeout.sv
// rtl/rx_fifo_drain_ctrl_timeout.sv - idle timeout counter that triggers partial-burst flushes
module rx_drain_timeout
  import qspi_rx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_idle,
  input  logic [LVL_W-1:0] i_level,
  input  logic [LVL_W-1:0] i_eff_len,
  input  logic [TMO_W-1:0] i_timeout,
  input  logic             i_fifo_rd,
  output logic             o_expire
);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_run;

  // Count only while idle holding a partial burst's worth of data.
  assign w_run = i_idle && (i_level != '0) && (i_level < i_eff_len);

  // Counter clears whenever the partial-idle condition breaks or the FIFO is read; it saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (!w_run || i_fifo_rd) begin
      r_tmo_cnt <= '0;
    end else if (r_tmo_cnt != '1) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  assign o_expire = w_run && (i_timeout != '0) && (r_tmo_cnt == i_timeout - TMO_W'(1));

endmodule

// File: rtl/rx_fifo_drain_ctrl.sv
// rtl/rx_fifo_drain_ctrl.sv - arbitrates the RX FIFO read port between CSR reads and DMA bursts
module rx_fifo_drain_ctrl
  import qspi_rx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  rx_fifo_drain_ctrl_if.master bus
);

  drain_state_t     r_state;
  drain_state_t     w_next_state;
  logic             r_dma_req;
  logic [LVL_W-1:0] r_dma_len;
  logic [LVL_W-1:0] r_beats_left;
  logic             r_flush_evt;

  logic [LVL_W-1:0] w_eff_len;
  logic             w_idle;
  logic             w_busy;
  logic             w_expire;
  logic             w_launch_norm;
  logic             w_launch_flush;
  logic             w_dma_valid;
  logic             w_beat;
  logic             w_csr_re;

  assign w_eff_len = eff_len(bus.cfg_burst_len);
  assign w_idle    = (r_state == IDLE);
  assign w_busy    = !w_idle;

  // CSR reads are served only while idle; a pending read also suppresses any launch this cycle.
  assign w_csr_re       = w_idle && bus.csr_rd_req && !bus.fifo_empty;
  assign w_launch_norm  = w_idle && bus.cfg_dma_en && !bus.csr_rd_req && (bus.fifo_level >= w_eff_len);
  assign w_launch_flush = w_idle && bus.cfg_dma_en && !bus.csr_rd_req && w_expire;

  assign w_dma_valid = (r_state == BURST) && !bus.fifo_empty && bus.cfg_dma_en && (r_beats_left != '0);
  assign w_beat      = w_dma_valid && bus.dma_ready;

  rx_drain_timeout u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_idle    (w_idle),
    .i_level   (bus.fifo_level),
    .i_eff_len (w_eff_len),
    .i_timeout (bus.cfg_timeout),
    .i_fifo_rd (w_csr_re || w_beat),
    .o_expire  (w_expire)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: launch from idle, finish on the final beat, abort if DMA mode is withdrawn.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_launch_norm || w_launch_flush) begin
          w_next_state = BURST;
        end
      end
      BURST: begin
        if (!bus.cfg_dma_en) begin
          w_next_state = IDLE;
        end else if (w_beat && (r_beats_left == LVL_W'(1))) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Burst bookkeeping: length latch on launch, beat countdown, registered request and flush pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dma_req    <= 1'b0;
      r_dma_len    <= '0;
      r_beats_left <= '0;
      r_flush_evt  <= 1'b0;
    end else begin
      r_dma_req   <= (w_next_state == BURST);
      r_flush_evt <= w_launch_flush;
      if (w_launch_norm) begin
        r_dma_len    <= w_eff_len;
        r_beats_left <= w_eff_len;
      end else if (w_launch_flush) begin
        r_dma_len    <= bus.fifo_level;
        r_beats_left <= bus.fifo_level;
      end else if ((r_state == BURST) && !bus.cfg_dma_en) begin
        r_beats_left <= '0;
      end else if (w_beat && (r_beats_left != '0)) begin
        r_beats_left <= r_beats_left - LVL_W'(1);
      end
    end
  end

  assign bus.fifo_csr_re  = w_csr_re;
  assign bus.fifo_dma_re  = w_beat;
  assign bus.dma_req      = r_dma_req;
  assign bus.dma_len      = r_dma_len;
  assign bus.dma_valid    = w_dma_valid;
  assign bus.burst_done   = (r_state == DONE);
  assign bus.flush_evt    = r_flush_evt;
  assign bus.csr_conflict = w_busy && bus.csr_rd_req;
  assign bus.csr_underrun = w_idle && bus.csr_rd_req && bus.fifo_empty;

endmodule

// File: tb/tb_rx_fifo_drain_ctrl.sv
// tb/tb_rx_fifo_drain_ctrl.sv - directed self-checking bench for rx_fifo_drain_ctrl
module tb_rx_fifo_drain_ctrl;
  import qspi_rx_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] lvl = 5'd0;
  logic [4:0] wr_n = 5'd0;
  int         beats = 0;
  int         checks = 0;
  int         errors = 0;
  int         b0;
  logic       found;

  rx_fifo_drain_ctrl_if bus();

  rx_fifo_drain_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.fifo_level = lvl;
  assign bus.fifo_empty = (lvl == 5'd0);

  // FIFO occupancy model: words pushed by the stimulus minus words popped by either read strobe.
  always @(posedge clk) begin
    lvl <= lvl + wr_n - {4'd0, (bus.fifo_csr_re | bus.fifo_dma_re)};
    if (bus.fifo_dma_re) beats <= beats + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] n);
    wr_n = n;
    tick();
    wr_n = 5'd0;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) chk("read_port_exclusive", {31'd0, bus.fifo_csr_re & bus.fifo_dma_re}, 32'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.cfg_dma_en    = 1'b0;
    bus.cfg_burst_len = 5'd0;
    bus.cfg_timeout   = 16'd0;
    bus.csr_rd_req    = 1'b0;
    bus.dma_ready     = 1'b0;
    tick();
    tick();
    chk("rst_dma_req", bus.dma_req, 0);
    chk("rst_dma_len", bus.dma_len, 0);
    chk("rst_burst_done", bus.burst_done, 0);
    chk("rst_flush_evt", bus.flush_evt, 0);
    chk("rst_state", dut.r_state, IDLE);
    rst_n = 1'b1;

    // Normal 4-word burst, ready held high.
    bus.cfg_dma_en = 1'b1; bus.cfg_burst_len = 5'd4; bus.dma_ready = 1'b1;
    b0 = beats;
    push(5'd1); push(5'd1); push(5'd1); push(5'd1);
    chk("n_level4_no_req", bus.dma_req, 0);
    tick();
    chk("n_dma_req", bus.dma_req, 1);
    chk("n_dma_len", bus.dma_len, 4);
    chk("n_dma_valid", bus.dma_valid, 1);
    chk("n_first_beat", bus.fifo_dma_re, 1);
    tick(); tick(); tick();
    chk("n_req_last_beat", bus.dma_req, 1);
    tick();
    chk("n_burst_done", bus.burst_done, 1);
    chk("n_req_dropped", bus.dma_req, 0);
    chk("n_beats", beats - b0, 4);
    chk("n_level0", lvl, 0);
    tick();
    chk("n_done_single", bus.burst_done, 0);

    // CSR read blocked during burst, then ready toggled 1/0.
    bus.dma_ready = 1'b0;
    b0 = beats;
    push(5'd4);
    tick();
    chk("c_dma_req", bus.dma_req, 1);
    bus.csr_rd_req = 1'b1;
    #1;
    chk("c_conflict", bus.csr_conflict, 1);
    chk("c_csr_re_blocked", bus.fifo_csr_re, 0);
    tick();
    bus.csr_rd_req = 1'b0;
    chk("c_level_kept", lvl, 4);
    for (int i = 0; i < 7; i++) begin
      bus.dma_ready = (i % 2 == 0);
      #1;
      chk("t_beat_follows_ready", bus.fifo_dma_re, (i % 2 == 0));
      tick();
    end
    chk("t_burst_done", bus.burst_done, 1);
    chk("t_beats", beats - b0, 4);
    chk("t_level0", lvl, 0);
    bus.dma_ready = 1'b1;
    tick();

    // CSR read on empty FIFO, then CSR read on non-empty FIFO in idle.
    bus.csr_rd_req = 1'b1;
    #1;
    chk("u_underrun", bus.csr_underrun, 1);
    chk("u_no_csr_re", bus.fifo_csr_re, 0);
    chk("u_no_conflict", bus.csr_conflict, 0);
    tick();
    bus.csr_rd_req = 1'b0;
    push(5'd1);
    bus.csr_rd_req = 1'b1;
    #1;
    chk("r_csr_re", bus.fifo_csr_re, 1);
    chk("r_no_underrun", bus.csr_underrun, 0);
    tick();
    bus.csr_rd_req = 1'b0;
    chk("r_level0", lvl, 0);

    // Timeout flush of a 3-word partial burst.
    bus.cfg_burst_len = 5'd8; bus.cfg_timeout = 16'd10;
    b0 = beats;
    push(5'd3);
    repeat (9) tick();
    chk("f_no_req_early", bus.dma_req, 0);
    chk("f_no_flush_early", bus.flush_evt, 0);
    tick();
    chk("f_flush_evt", bus.flush_evt, 1);
    chk("f_dma_req", bus.dma_req, 1);
    chk("f_dma_len", bus.dma_len, 3);
    tick();
    chk("f_flush_pulse", bus.flush_evt, 0);
    tick(); tick();
    chk("f_burst_done", bus.burst_done, 1);
    chk("f_beats", beats - b0, 3);
    chk("f_level0", lvl, 0);
    bus.cfg_timeout = 16'd0;
    tick();

    // Abort after 2 of 4 beats.
    bus.cfg_burst_len = 5'd4;
    b0 = beats;
    push(5'd4);
    tick(); tick(); tick();
    bus.cfg_dma_en = 1'b0;
    #1;
    chk("a_valid_off", bus.dma_valid, 0);
    chk("a_no_beat", bus.fifo_dma_re, 0);
    tick();
    chk("a_dma_req", bus.dma_req, 0);
    chk("a_no_done", bus.burst_done, 0);
    chk("a_state", dut.r_state, IDLE);
    chk("a_level2", lvl, 2);
    chk("a_beats", beats - b0, 2);
    bus.csr_rd_req = 1'b1;
    tick(); tick();
    bus.csr_rd_req = 1'b0;
    chk("a_drained", lvl, 0);

    // Burst length 0 behaves as 1.
    bus.cfg_dma_en = 1'b1; bus.cfg_burst_len = 5'd0;
    push(5'd1);
    chk("z_no_req", bus.dma_req, 0);
    tick();
    chk("z_dma_req", bus.dma_req, 1);
    chk("z_dma_len", bus.dma_len, 1);
    tick();
    chk("z_burst_done", bus.burst_done, 1);
    tick();

    // Burst length 31 saturates at 16: launches only when full.
    bus.cfg_burst_len = 5'd31;
    b0 = beats;
    push(5'd15);
    tick(); tick(); tick();
    chk("s_no_req_15", bus.dma_req, 0);
    chk("s_level15", lvl, 15);
    push(5'd1);
    chk("s_no_req_yet", bus.dma_req, 0);
    tick();
    chk("s_dma_req", bus.dma_req, 1);
    chk("s_dma_len", bus.dma_len, 16);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.burst_done) found = 1'b1;
    end
    chk("s_done_seen", found, 1);
    chk("s_beats", beats - b0, 16);
    chk("s_level0", lvl, 0);
    tick();

    // CSR read in the launch cycle defers the launch.
    bus.cfg_burst_len = 5'd2;
    push(5'd2);
    bus.csr_rd_req = 1'b1;
    #1;
    chk("d_csr_wins", bus.fifo_csr_re, 1);
    tick();
    bus.csr_rd_req = 1'b0;
    chk("d_no_req", bus.dma_req, 0);
    chk("d_level1", lvl, 1);
    push(5'd1);
    tick();
    chk("d_relaunch", bus.dma_req, 1);
    tick(); tick();
    chk("d_burst_done", bus.burst_done, 1);
    tick();

    // Reset mid-burst.
    bus.cfg_burst_len = 5'd4; bus.dma_ready = 1'b0;
    push(5'd4);
    tick();
    chk("m_dma_req", bus.dma_req, 1);
    rst_n = 1'b0;
    #1;
    chk("m_req_cleared", bus.dma_req, 0);
    chk("m_no_done", bus.burst_done, 0);
    chk("m_state", dut.r_state, IDLE);
    chk("m_level_kept", lvl, 4);
    tick();
    rst_n = 1'b1;
    bus.dma_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (bus.burst_done) found = 1'b1;
    end
    chk("m_done_after_reset", found, 1);
    chk("m_level0", lvl, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
